memory_interface: RTL
=====================

MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, meaning memory address width.
REQ-002 The block SHALL have parameter DEPTH, default 512, meaning the number of 32-bit memory words.
REQ-003 The block SHALL have parameter RD_LAT, default 2, legal range 1..7, meaning read latency in cycles.
REQ-004 Clock  in  1  system clock; all state changes on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 BusMuxOut  in  32  datapath bus value.
REQ-007 MARin  in  1  load MAR from BusMuxOut[ADDR_W-1:0].
REQ-008 MDRin  in  1  load MDR; source selected by Read.
REQ-009 Read  in  1  with MDRin, start a memory read; low means load MDR from bus.
REQ-010 Write  in  1  memory write request, rising-edge detected.
REQ-011 MDR_q  out  32  MDR contents, driven to the bus mux.
REQ-012 MAR_q  out  ADDR_W  MAR contents.
REQ-013 Busy  out  1  high while a read or write is in progress.
REQ-014 Done  out  1  one-cycle pulse on completion of a read or write.
REQ-015 Collision  out  1  one-cycle pulse when a write request is dropped.

Function
REQ-016 The FSM SHALL have states IDLE, RD_WAIT and WR.
REQ-017 In IDLE, with MARin=1, MAR SHALL load BusMuxOut[ADDR_W-1:0] at the clock edge.
REQ-018 In IDLE, with MDRin=1 and Read=0, MDR SHALL load BusMuxOut at the clock edge.
REQ-019 In IDLE, MDRin=1 with Read=1 sampled at edge k SHALL cause a transition to RD_WAIT, with Busy=1 from edge k.
REQ-020 An internal counter SHALL count RD_LAT cycles in RD_WAIT.
REQ-021 At edge k+RD_LAT, MDR SHALL load mem[MAR], Done SHALL be 1 for exactly one cycle, Busy SHALL be 0, and the state SHALL return to IDLE.
REQ-022 A write request is Write=1 at an edge where the registered Write_d=0, in IDLE.
REQ-023 A write request at edge k SHALL cause a transition to WR, with Busy=1.
REQ-024 At edge k+1, mem[MAR] SHALL be written with MDR, Done SHALL pulse for one cycle, Busy SHALL be 0, and the state SHALL return to IDLE.
REQ-025 Write held high SHALL start no further writes until Write returns low and rises again.
REQ-026 Write_d SHALL update every cycle regardless of state.
REQ-027 While Busy=1, MARin, MDRin, Read and write requests SHALL be ignored, so MAR and MDR hold stable.
REQ-028 A write rising edge occurring while Busy=1 SHALL be consumed, not queued, and SHALL pulse Collision.
REQ-029 If a read request and a write request occur at the same IDLE edge, the read SHALL win, the write SHALL be dropped, and Collision SHALL pulse for one cycle.
REQ-030 If MARin and a read request occur at the same IDLE edge, MAR SHALL load first and the read SHALL use the new MAR value.
REQ-031 The memory read address SHALL be MAR as registered at the read-request edge; the read returns the old MAR value only if MARin is absent.
REQ-032 MAR SHALL wrap naturally at ADDR_W bits; upper bus bits are ignored; no out-of-range detection.
REQ-033 The next read request SHALL be accepted at the first IDLE edge after Done.

Reset
REQ-034 Reset=1 SHALL immediately force state IDLE, MAR=0, MDR=0, counter=0, Write_d=0, Busy=0, Done=0 and Collision=0.
REQ-035 Reset asserted mid-read or mid-write SHALL abort the operation: no MDR update, no memory write, no Done pulse.
REQ-036 Memory contents SHALL NOT be cleared by Reset.
REQ-037 The first request SHALL be accepted at the first rising edge after Reset deasserts.

Verification
REQ-038 Write-then-read: MARin with bus=0x0000_0014; MDRin/Read=0 with bus=0xDEAD_BEEF; pulse Write -> Busy for 1 cycle, Done pulse. Then clear MDR, issue MDRin+Read -> after RD_LAT=2 edges MDR_q=0xDEAD_BEEF and Done pulses once.
REQ-039 Busy lockout: during RD_WAIT drive MARin with bus=0x0000_0033 and MDRin/Read=0 with bus=0x1234_5678 -> MAR_q and MDR_q unchanged until Done.
REQ-040 Held Write: hold Write high 5 cycles with MAR=7, MDR=0xA5A5_A5A5 -> exactly one Done pulse; mem[7]=0xA5A5_A5A5.
REQ-041 Simultaneous: read request plus Write rising at the same edge -> Collision=1 for 1 cycle, read completes, target memory word unchanged.
REQ-042 Reset mid-read: assert Reset one cycle after the read request -> MDR_q=0, Busy=0, no Done; after release, a read of the same address returns the stored value.
REQ-043 Wrap: MARin with bus=0xFFFF_FE05 -> MAR_q=0x005 (ADDR_W=9); a write then a read at that address round-trips the data.

Source files
------------

// File: rtl/memory_interface.sv
// Memory interface: MAR/MDR register pair in front of a single-port word
// memory. Reads take RD_LAT cycles, writes take one cycle. While an access
// is in flight the bus controls are locked out; a write rising edge that
// cannot be serviced is dropped and flagged with Collision.
module memory_interface #(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512,
   parameter int RD_LAT = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [31:0]       BusMuxOut,
   input  logic              MARin,
   input  logic              MDRin,
   input  logic              Read,
   input  logic              Write,
   output logic [31:0]       MDR_q,
   output logic [ADDR_W-1:0] MAR_q,
   output logic              Busy,
   output logic              Done,
   output logic              Collision
);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      WR
   } state_t;

   // Terminal count of the read-latency counter (RD_LAT is 1..7).
   localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

   state_t      state;
   state_t      state_next;
   logic [2:0]  cnt;
   logic [2:0]  cnt_next;
   logic        Write_d;
   logic [31:0] mem [DEPTH];

   logic        write_req;
   logic        read_req;
   logic        mar_load;
   logic        mdr_load_bus;
   logic        mdr_load_mem;
   logic        mem_we;
   logic        done_next;
   logic        collision_next;

   // Only the low ADDR_W bus bits reach MAR; the rest are deliberately unused.
   logic        unused_bus;
   assign unused_bus = ^BusMuxOut;

   // A write request is a rising edge of Write; a read request is MDRin+Read.
   assign write_req = Write & ~Write_d;
   assign read_req  = MDRin & Read;

   // Any non-idle state is an access in progress.
   assign Busy = (state != IDLE);

   // State register.
   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking (=) here would create order-dependent races.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath control decode.
   // NOTE: every signal gets a default first so no path leaves it unassigned;
   // a missing default in always_comb would infer a latch.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      mar_load       = 1'b0;
      mdr_load_bus   = 1'b0;
      mdr_load_mem   = 1'b0;
      mem_we         = 1'b0;
      done_next      = 1'b0;
      collision_next = 1'b0;
      case (state)
         IDLE: begin
            // MAR loads on the same edge as a read request, so the read
            // picks up the new address.
            mar_load = MARin;
            if (read_req) begin
               state_next     = RD_WAIT;
               cnt_next       = '0;
               collision_next = write_req;
            end else begin
               mdr_load_bus = MDRin;
               if (write_req) begin
                  state_next = WR;
               end
            end
         end
         RD_WAIT: begin
            collision_next = write_req;
            if (cnt == CNT_LAST) begin
               mdr_load_mem = 1'b1;
               done_next    = 1'b1;
               cnt_next     = '0;
               state_next   = IDLE;
            end else begin
               cnt_next = cnt + 3'd1;
            end
         end
         WR: begin
            collision_next = write_req;
            mem_we         = 1'b1;
            done_next      = 1'b1;
            state_next     = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // MAR, MDR, latency counter, Write edge detector and completion pulses.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         MAR_q     <= '0;
         MDR_q     <= '0;
         cnt       <= '0;
         Write_d   <= 1'b0;
         Done      <= 1'b0;
         Collision <= 1'b0;
      end else begin
         Write_d   <= Write;
         cnt       <= cnt_next;
         Done      <= done_next;
         Collision <= collision_next;
         if (mar_load) begin
            MAR_q <= BusMuxOut[ADDR_W-1:0];
         end
         if (mdr_load_mem) begin
            MDR_q <= mem[MAR_q];
         end else if (mdr_load_bus) begin
            MDR_q <= BusMuxOut;
         end
      end
   end

   // Memory array write port; MAR and MDR are frozen while in WR.
   // NOTE: the array has no reset on purpose -- its contents must survive
   // Reset, and an unreset array maps onto plain RAM.
   always_ff @(posedge Clock) begin
      if (mem_we) begin
         mem[MAR_q] <= MDR_q;
      end
   end

endmodule
